alu_seq: RTL and testbench

- Parametrised, registered, multi-cycle successor to the 8-bit combinational OR unit; sits in the processor execute stage between the register file read ports and the writeback mux.
- Performs FORWARD/ADD/SUB/AND/OR in one cycle and MUL by iterative shift-add over WIDTH cycles.
- Uses a START/BUSY/DONE handshake so control logic can stall on multi-cycle ops.

---
 rtl/alu_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered, multi-cycle execute-stage ALU with a START/BUSY/DONE
//            handshake. FWD/ADD/SUB/AND/OR complete one edge after accept;
//            MUL iterates shift-add over WIDTH edges.
// Options  : ALU_SEQ_MUL_EN - when defined, builds the iterative multiplier;
//            otherwise opcode 100 completes as an illegal single-cycle op.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE,
  output logic             ILLEGAL
);

  localparam logic [2:0] c_op_fwd = 3'b000;
  localparam logic [2:0] c_op_add = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_or  = 3'b011;
  localparam logic [2:0] c_op_sub = 3'b101;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] c_op_mul = 3'b100;
  // Counter is sized to hold WIDTH so it can never wrap for any WIDTH.
  localparam int         CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1
`ifdef ALU_SEQ_MUL_EN
    ,
    S_MUL  = 2'd2
`endif
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;        // operand A; doubles as shifting multiplicand
  logic [WIDTH-1:0] b_q;        // operand B; doubles as shifting multiplier
  logic [2:0]       sel_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
  logic             illegal_q;
  logic [WIDTH-1:0] res_d;
  logic             ill_d;

`ifdef ALU_SEQ_MUL_EN
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
`endif

  // Single-cycle result from the latched operands; unknown opcodes yield 0.
  always_comb begin
    res_d = '0;
    ill_d = 1'b0;
    case (sel_q)
      c_op_fwd: res_d = b_q;
      c_op_add: res_d = a_q + b_q;
      c_op_and: res_d = a_q & b_q;
      c_op_or:  res_d = a_q | b_q;
      c_op_sub: res_d = a_q - b_q;
      default:  ill_d = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_d = acc_q + (b_q[0] ? a_q : '0);
  end
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cnt_q     <= '0;
      acc_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // DONE cycles are spent in IDLE, so a new op may be accepted then.
          if (START) begin
            a_q    <= DATA1;
            b_q    <= DATA2;
            sel_q  <= SELECT;
            busy_q <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            if (SELECT == c_op_mul) begin
              state_q <= S_MUL;
              cnt_q   <= '0;
              acc_q   <= '0;
            end else begin
              state_q <= S_EXEC;
            end
`else
            state_q <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          result_q  <= res_d;
          zero_q    <= (res_d == '0);
          illegal_q <= ill_d;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          // The WIDTH-th step writes its sum straight to the result.
          if (cnt_q == c_last_step) begin
            result_q  <= acc_d;
            zero_q    <= (acc_d == '0);
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign RESULT  = result_q;
  assign ZERO    = zero_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ILLEGAL = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=8): directed vector table,
//            hand-written handshake sequences and randomized ops against a
//            plain-arithmetic reference model.
// Options  : ALU_SEQ_MUL_EN selects multiplier or illegal-op expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic [2:0]   SELECT = 3'b000;
  logic [W-1:0] DATA1 = '0;
  logic [W-1:0] DATA2 = '0;
  logic [W-1:0] RESULT;
  logic         ZERO, BUSY, DONE, ILLEGAL;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO),
    .BUSY(BUSY), .DONE(DONE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ill;
    int           lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the arithmetic meaning of each opcode.
  task automatic model(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic ill, output int lat);
    int prod;
    res = '0; ill = 1'b0; lat = 1;
    case (sel)
      3'd0: res = b;
      3'd1: res = W'(int'(a) + int'(b));
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd5: res = W'(int'(a) - int'(b));
      3'd4: begin
        if (MUL_ON) begin
          prod = int'(a) * int'(b);
          res  = W'(prod % 256);
          lat  = W;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
  endtask

  // Issue one op from a negedge with BUSY=0; optionally keep START high with
  // junk operands while busy. Returns at a negedge with the DUT idle.
  task automatic do_op(input string nm, input logic [2:0] sel, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic ei,
                       input int elat, input bit hold);
    int lat;
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    @(posedge CLK); @(negedge CLK);
    chk({nm, " busy"}, 32'(BUSY), 32'd1);
    START  = hold;
    SELECT = 3'($urandom_range(0, 7));
    DATA1  = W'($urandom);
    DATA2  = W'($urandom);
    lat = 0;
    for (int i = 1; i <= W + 4; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (DONE) begin lat = i; break; end
    end
    START = 1'b0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=no_done expected=done_after_%0d", nm, elat);
    end else begin
      chk({nm, " latency"}, 32'(lat), 32'(elat));
      chk({nm, " result"}, 32'(RESULT), 32'(er));
      chk({nm, " zero"}, 32'(ZERO), 32'(er == '0));
      chk({nm, " illegal"}, 32'(ILLEGAL), 32'(ei));
      chk({nm, " notbusy"}, 32'(BUSY), 32'd0);
      @(posedge CLK); @(negedge CLK);
      chk({nm, " done_pulse"}, 32'(DONE), 32'd0);
      chk({nm, " result_hold"}, 32'(RESULT), 32'(er));
    end
  endtask

  vec_t vt[10];

  initial begin
    logic [W-1:0] er;
    logic         ei;
    int           el;
    bit           saw_done;

    vt[0] = '{3'b011, 8'hD4, 8'h0A, 8'hDE, 1'b0, 1};
    vt[1] = '{3'b001, 8'h7F, 8'h01, 8'h80, 1'b0, 1};
    vt[2] = '{3'b001, 8'hFF, 8'h01, 8'h00, 1'b0, 1};
    vt[3] = '{3'b101, 8'h05, 8'h07, 8'hFE, 1'b0, 1};
    vt[4] = '{3'b100, 8'h0F, 8'h0B, MUL_ON ? 8'hA5 : 8'h00, !MUL_ON, MUL_ON ? W : 1};
    vt[5] = '{3'b100, 8'hFD, 8'h05, MUL_ON ? 8'hF1 : 8'h00, !MUL_ON, MUL_ON ? W : 1};
    vt[6] = '{3'b110, 8'h12, 8'h34, 8'h00, 1'b1, 1};
    vt[7] = '{3'b000, 8'h99, 8'h3C, 8'h3C, 1'b0, 1};
    vt[8] = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1};
    vt[9] = '{3'b111, 8'hAA, 8'h55, 8'h00, 1'b1, 1};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst result", 32'(RESULT), 32'h0);
    chk("rst zero", 32'(ZERO), 32'd1);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst done", 32'(DONE), 32'd0);
    chk("rst illegal", 32'(ILLEGAL), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Directed table
    foreach (vt[i])
      do_op($sformatf("vec%0d", i), vt[i].sel, vt[i].a, vt[i].b, vt[i].res, vt[i].ill, vt[i].lat, 1'b0);

    // START held with other operands while busy must be ignored
    do_op("mul_hold", 3'b100, 8'h0F, 8'h0B, MUL_ON ? 8'hA5 : 8'h00, !MUL_ON, MUL_ON ? W : 1, 1'b1);
    do_op("or_hold", 3'b011, 8'h40, 8'h02, 8'h42, 1'b0, 1, 1'b1);

    // Back-to-back with START held: AND then OR
    START = 1'b1; SELECT = 3'b010; DATA1 = 8'hF0; DATA2 = 8'h3C;
    @(posedge CLK); @(negedge CLK);
    SELECT = 3'b011; DATA1 = 8'h01; DATA2 = 8'h02;
    @(posedge CLK); @(negedge CLK);
    chk("b2b done1", 32'(DONE), 32'd1);
    chk("b2b res1", 32'(RESULT), 32'h30);
    @(posedge CLK); @(negedge CLK);
    START = 1'b0;
    chk("b2b busy2", 32'(BUSY), 32'd1);
    chk("b2b gap", 32'(DONE), 32'd0);
    @(posedge CLK); @(negedge CLK);
    chk("b2b done2", 32'(DONE), 32'd1);
    chk("b2b res2", 32'(RESULT), 32'h03);
    @(posedge CLK); @(negedge CLK);

    // Reset in the middle of a multiply
    START = 1'b1; SELECT = 3'b100; DATA1 = 8'h0F; DATA2 = 8'h0B;
    @(posedge CLK); @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("midrst result", 32'(RESULT), 32'h0);
    chk("midrst zero", 32'(ZERO), 32'd1);
    chk("midrst busy", 32'(BUSY), 32'd0);
    chk("midrst done", 32'(DONE), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge CLK);
      if (DONE) saw_done = 1'b1;
    end
    chk("midrst no_done", 32'(saw_done), 32'd0);
    do_op("after_rst_or", 3'b011, 8'h01, 8'h00, 8'h01, 1'b0, 1, 1'b0);

    // Randomized ops against the model
    for (int n = 0; n < 40; n++) begin
      logic [2:0]   s;
      logic [W-1:0] a, b;
      s = 3'($urandom_range(0, 7));
      a = W'($urandom);
      b = W'($urandom);
      if (n % 8 == 0) b = W'(0 - int'(a));   // steer ADD-style zero results
      model(s, a, b, er, ei, el);
      do_op($sformatf("rnd%0d_sel%0d", n, s), s, a, b, er, ei, el, n[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
